// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution,
// and the EX/MEM pipeline register plus the registered fetch redirect.
module ex_stage #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_OUT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_ex,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] rs1_ex,
  input  logic [XLEN-1:0] rs2_ex,
  input  logic [4:0]      rs1_addr_ex,
  input  logic [4:0]      rs2_addr_ex,
  input  logic [4:0]      rd_ex,
  input  logic [XLEN-1:0] imm_ex,
  input  logic [3:0]      alu_op,
  input  logic            alu_src,
  input  logic [2:0]      br_type,
  input  logic            branch_ex,
  input  logic            jal_ex,
  input  logic            jalr_ex,
  input  logic            reg_write_ex,
  input  logic            mem_read_ex,
  input  logic            mem_write_ex,
  input  logic [4:0]      wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] alu_result_mem,
  output logic [XLEN-1:0] store_data_mem,
  output logic [4:0]      rd_mem,
  output logic            reg_write_mem,
  output logic            mem_read_mem,
  output logic            mem_write_mem,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] sd;
    logic [4:0]      rd;
    logic            rw;
    logic            mr;
    logic            mw;
  } exmem_t;

  localparam exmem_t BUBBLE = '0;

  exmem_t          exmem_q, exmem_d;
  logic [XLEN-1:0] fwd_a, fwd_b, opb, alu_out, target;
  logic [4:0]      shamt;
  logic            taken, redir_d;

  // MEM result wins over WB; x0 is never forwarded even if marked written.
  always_comb begin
    fwd_a = rs1_ex;
    if (exmem_q.rw && exmem_q.rd != 5'd0 && exmem_q.rd == rs1_addr_ex)
      fwd_a = exmem_q.alu;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs1_addr_ex)
      fwd_a = wb_result;
  end

  always_comb begin
    fwd_b = rs2_ex;
    if (exmem_q.rw && exmem_q.rd != 5'd0 && exmem_q.rd == rs2_addr_ex)
      fwd_b = exmem_q.alu;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs2_addr_ex)
      fwd_b = wb_result;
  end

  assign opb   = alu_src ? imm_ex : fwd_b;
  assign shamt = opb[4:0];

  always_comb begin
    alu_out = '0;
    case (alu_op)
      4'd0:    alu_out = fwd_a + opb;
      4'd1:    alu_out = fwd_a - opb;
      4'd2:    alu_out = fwd_a << shamt;
      4'd3:    alu_out = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(opb)};
      4'd4:    alu_out = {{(XLEN-1){1'b0}}, fwd_a < opb};
      4'd5:    alu_out = fwd_a ^ opb;
      4'd6:    alu_out = fwd_a >> shamt;
      4'd7:    alu_out = $unsigned($signed(fwd_a) >>> shamt);
      4'd8:    alu_out = fwd_a | opb;
      4'd9:    alu_out = fwd_a & opb;
      4'd10:   alu_out = opb;
      4'd11:   alu_out = pc_ex + imm_ex;
      default: alu_out = '0;
    endcase
  end

  // Branch compare uses forwarded rs2, never the immediate.
  always_comb begin
    taken = 1'b0;
    case (br_type)
      3'b000:  taken = (fwd_a == fwd_b);
      3'b001:  taken = (fwd_a != fwd_b);
      3'b100:  taken = ($signed(fwd_a) <  $signed(fwd_b));
      3'b101:  taken = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110:  taken = (fwd_a <  fwd_b);
      3'b111:  taken = (fwd_a >= fwd_b);
      default: taken = 1'b0;
    endcase
  end

  assign target  = jalr_ex ? ((fwd_a + imm_ex) & ~XLEN'(1)) : (pc_ex + imm_ex);
  assign redir_d = (branch_ex && taken) || jal_ex || jalr_ex;

  always_comb begin
    exmem_d     = BUBBLE;
    exmem_d.alu = (jal_ex || jalr_ex) ? (pc_ex + XLEN'(4)) : alu_out;
    exmem_d.sd  = fwd_b;
    exmem_d.rd  = rd_ex;
    exmem_d.rw  = reg_write_ex;
    exmem_d.mr  = mem_read_ex;
    exmem_d.mw  = mem_write_ex;
  end

  // Bubbles leave redirect_pc untouched; only redirect itself is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem_q     <= BUBBLE;
      redirect    <= 1'b0;
      redirect_pc <= RESET_PC_OUT;
    end else if (flush) begin
      exmem_q  <= BUBBLE;
      redirect <= 1'b0;
    end else if (!stall) begin
      if (valid_ex) begin
        exmem_q     <= exmem_d;
        redirect    <= redir_d;
        redirect_pc <= target;
      end else begin
        exmem_q  <= BUBBLE;
        redirect <= 1'b0;
      end
    end
  end

  assign alu_result_mem = exmem_q.alu;
  assign store_data_mem = exmem_q.sd;
  assign rd_mem         = exmem_q.rd;
  assign reg_write_mem  = exmem_q.rw;
  assign mem_read_mem   = exmem_q.mr;
  assign mem_write_mem  = exmem_q.mw;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the in-order 5-stage RV32I pipeline; consumes the ID/EX register outputs.
- Selects forwarded operands, performs ALU and branch/jump resolution, and drives the branch redirect.
- Captures results in an internal EX/MEM pipeline register that feeds the memory stage.
- Forwards from its own EX/MEM register (MEM→EX) and from the writeback port (WB→EX).

Parameters:
- XLEN, 32, datapath width
- RESET_PC_OUT, 32'h0000_0000, reset value of redirect_pc

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- stall  in  1  hold EX/MEM register contents (MEM stage busy)
- flush  in  1  load a bubble into EX/MEM
- valid_ex  in  1  ID/EX holds a real instruction
- pc_ex  in  32  instruction PC
- rs1_ex  in  32  rs1 value from ID/EX
- rs2_ex  in  32  rs2 value from ID/EX
- rs1_addr_ex  in  5  rs1 index
- rs2_addr_ex  in  5  rs2 index
- rd_ex  in  5  destination index
- imm_ex  in  32  sign-extended immediate
- alu_op  in  4  ALU operation code
- alu_src  in  1  0: operand B = rs2, 1: operand B = imm
- br_type  in  3  branch funct3
- branch_ex  in  1  conditional branch
- jal_ex  in  1  JAL
- jalr_ex  in  1  JALR
- reg_write_ex  in  1  writes rd
- mem_read_ex  in  1  load
- mem_write_ex  in  1  store
- wb_rd  in  5  WB-stage destination
- wb_reg_write  in  1  WB-stage write enable
- wb_result  in  32  WB-stage write data
- alu_result_mem  out  32  registered ALU result or link address
- store_data_mem  out  32  registered forwarded rs2 value
- rd_mem  out  5  registered rd
- reg_write_mem  out  1  registered write enable
- mem_read_mem  out  1  registered load flag
- mem_write_mem  out  1  registered store flag
- redirect  out  1  registered: fetch must jump and flush IF/ID and ID/EX
- redirect_pc  out  32  registered redirect target

Behaviour:
- Reset (async, rst=1): every registered output → 0; redirect_pc → RESET_PC_OUT. No instruction retires until rst deasserts.
- Forwarding, operand A:
  - if reg_write_mem && rd_mem!=0 && rd_mem==rs1_addr_ex → alu_result_mem (takes priority);
  - else if wb_reg_write && wb_rd!=0 && wb_rd==rs1_addr_ex → wb_result;
  - else rs1_ex.
- Forwarding, operand B: same rules with rs2_addr_ex. Forwarded rs2 supplies both store data and the branch compare; operand B = alu_src ? imm_ex : forwarded rs2.
- alu_op codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B (LUI), 11 pc_ex+imm_ex (AUIPC).
  - Shift amount = B[4:0]; SLT/SLTU yield 0/1; all arithmetic wraps mod 2^32.
  - Codes 12–15 yield 0.
- Branch taken (branch_ex):
  - br_type 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU, computed on forwarded A/B;
  - 010/011 never taken.
- Jumps:
  - JAL target = pc_ex+imm_ex.
  - JALR target = (A+imm_ex) & ~1.
  - Conditional-branch target = pc_ex+imm_ex.
  - For jal/jalr the EX/MEM result is pc_ex+4.
- Clock edge, priority flush > stall > advance:
  - flush: EX/MEM control bits (reg_write/mem_read/mem_write) ← 0, rd_mem ← 0, data ← 0; redirect ← 0.
  - stall: all EX/MEM and redirect registers hold; forwarding still reads held values.
  - advance with valid_ex=1: load results; redirect ← taken|jal|jalr; redirect_pc ← target.
  - advance with valid_ex=0: insert bubble as for flush.
- redirect is a one-cycle pulse: next advancing edge clears it unless the new instruction also redirects.
- Stall and flush both high → flush wins.
- Writes to x0: rd_mem may equal 0 with reg_write_mem=1, but it is never forwarded.

Test Plan:
- Reset mid-stream: assert rst asynchronously between edges → all outputs 0 immediately; redirect_pc = 0.
- ADD x3,x1,x2 with rs1_ex=5, rs2_ex=7 → after 1 edge: alu_result_mem=12, rd_mem=3, reg_write_mem=1; SRA of 0x8000_0000 by 4 → 0xF800_0000.
- Back-to-back dependency: ADDI x1 result 10 in EX/MEM and WB also writing x1=99; next SUB x4,x1,x0 → result 10 (MEM priority). Same case with rd=0 → stale rs1_ex used.
- BLT with A=0xFFFF_FFFF, B=1, pc=0x100, imm=0x20 → redirect=1, redirect_pc=0x120 for one cycle; BLTU with same operands → redirect=0.
- JALR pc=0x40, A=0x1001, imm=2 → redirect_pc=0x1002, alu_result_mem=0x44.
- stall held 3 cycles with new inputs changing → outputs frozen; stall+flush together → bubble (reg_write_mem=0, mem_write_mem=0).
